// File: rtl/arb_mux_reg.sv
// N-channel valid/ready selector with one registered output stage; direct or round-robin grant.
// Optional packet lock (RR mode holds grant until in_last) is enabled by defining ARB_MUX_PKT_LOCK_EN.
module arb_mux_reg #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef ARB_MUX_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int               NSLOT   = 2 ** SEL_W;
  localparam logic [SEL_W:0]   CH_EXT  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  // Pad channel vectors to the full select range so any sel value indexes safely.
  logic [WIDTH-1:0] slot_data [NSLOT];
  logic [NSLOT-1:0] slot_valid;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic [NSLOT-1:0] slot_last;
`endif

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi < CHANNELS) begin : g_real
      assign slot_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign slot_valid[gi] = in_valid[gi];
`ifdef ARB_MUX_PKT_LOCK_EN
      assign slot_last[gi]  = in_last[gi];
`endif
    end else begin : g_pad
      assign slot_data[gi]  = '0;
      assign slot_valid[gi] = 1'b0;
`ifdef ARB_MUX_PKT_LOCK_EN
      assign slot_last[gi]  = 1'b1;
`endif
    end
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] last_q, last_d;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
`endif

  logic [SEL_W-1:0] gnt;
  logic             gnt_ok;
  logic [SEL_W:0]   idx;
  logic             load_en;
  logic             xfer;

  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    idx    = '0;
    if (!mode) begin
      if (({1'b0, sel} < CH_EXT) && slot_valid[sel]) begin
        gnt    = sel;
        gnt_ok = 1'b1;
      end
    end else
`ifdef ARB_MUX_PKT_LOCK_EN
    if (lock_q) begin
      if (slot_valid[lock_chan_q]) begin
        gnt    = lock_chan_q;
        gnt_ok = 1'b1;
      end
    end else
`endif
    begin
      // Scan farthest-first so the nearest valid channel after last_q wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        idx = {1'b0, last_q} + (SEL_W + 1)'(k);
        if (idx >= CH_EXT) idx = idx - CH_EXT;
        if (slot_valid[idx[SEL_W-1:0]]) begin
          gnt    = idx[SEL_W-1:0];
          gnt_ok = 1'b1;
        end
      end
    end
  end

  assign load_en = !valid_q || out_ready;
  assign xfer    = load_en && gnt_ok && !reset;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
    assign in_ready[gi] = xfer && (gnt == SEL_W'(gi));
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef ARB_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
`endif
    if (xfer) begin
      data_d  = slot_data[gnt];
      chan_d  = gnt;
      valid_d = 1'b1;
      if (mode) begin
`ifdef ARB_MUX_PKT_LOCK_EN
        if (slot_last[gnt]) begin
          last_d = gnt;
          lock_d = 1'b0;
        end else begin
          lock_d      = 1'b1;
          lock_chan_d = gnt;
        end
`else
        last_d = gnt;
`endif
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= LAST_CH;
`ifdef ARB_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
`endif
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef ARB_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: directed steps then random traffic against a queue-free reference model.
module tb_arb_mux_reg;
  localparam int W  = 24;
  localparam int C  = 8;
  localparam int SW = 3;
  localparam int C6 = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [C*W-1:0]  in_data;
  logic [C-1:0]    in_valid, in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid, out_ready;

  logic [C6*W-1:0] in_data6;
  logic [C6-1:0]   in_valid6, in_ready6;
  logic [SW-1:0]   sel6;
  logic [W-1:0]    out_data6;
  logic [SW-1:0]   out_chan6;
  logic            out_valid6;
  logic            mode6 = 1'b0;
  logic            out_ready6 = 1'b1;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic [C-1:0]    in_last  = '1;
  logic [C6-1:0]   in_last6 = '1;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit        m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int        m_chan = 0;
  int        m_ptr  = C - 1;
  bit        m6_valid = 1'b0;
  int        m6_chan  = 0;

  always #5 clk = ~clk;

  arb_mux_reg #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
`ifdef ARB_MUX_PKT_LOCK_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  arb_mux_reg #(.WIDTH(W), .CHANNELS(C6), .SEL_W(SW)) u_dut6 (
    .clk(clk), .reset(reset), .in_data(in_data6), .in_valid(in_valid6),
`ifdef ARB_MUX_PKT_LOCK_EN
    .in_last(in_last6),
`endif
    .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
    .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: check combinational ready before the edge, registered outputs after it.
  task automatic cycle();
    int g, g6;
    logic [C-1:0] er;
    logic [C6-1:0] er6;
    logic [7:0] v6p;
    logic [W-1:0] gd;
    bit md, rst, ordy;
    #1;
    md = mode; rst = reset; ordy = out_ready;
    g = -1;
    gd = '0;
    if (!rst && (!m_valid || ordy)) begin
      if (!md) begin
        if (int'(sel) < C && in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 1; k <= C; k++)
          if (g < 0 && in_valid[(m_ptr + k) % C]) g = (m_ptr + k) % C;
      end
    end
    er = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      gd = in_data[g*W +: W];
    end
    chk("in_ready", 32'(in_ready), 32'(er));

    v6p = {2'b00, in_valid6};
    g6 = -1;
    if (!rst && int'(sel6) < C6 && v6p[sel6]) g6 = int'(sel6);
    er6 = '0;
    if (g6 >= 0) er6[g6] = 1'b1;
    chk("in_ready6", 32'(in_ready6), 32'(er6));

    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = C - 1;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_data = gd; m_chan = g;
      if (md) m_ptr = g;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (rst) begin
      m6_valid = 1'b0; m6_chan = 0;
    end else if (g6 >= 0) begin
      m6_valid = 1'b1; m6_chan = g6;
    end else begin
      m6_valid = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_valid6", 32'(out_valid6), 32'(m6_valid));
    if (m6_valid) chk("out_chan6", 32'(out_chan6), 32'(m6_chan));
  endtask

  initial begin
    logic [W-1:0] held;
    int exp_seq [3];
    reset = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_data = '0; in_valid = '1; in_data6 = '0; in_valid6 = '1; sel6 = '0;

    // Reset: ready low even with everything valid, outputs cleared
    cycle();
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    reset = 1'b0; in_valid6 = '0;

    // Direct select of channel 3
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08;
    in_data[3*W +: W] = 24'hABCDEF;
    #1 chk("direct_ready", 32'(in_ready), 32'h08);
    cycle();
    chk("direct_data", 32'(out_data), 32'hABCDEF);
    chk("direct_chan", 32'(out_chan), 32'd3);
    chk("direct_valid", 32'(out_valid), 32'd1);

    // Six-channel instance: out-of-range selects never grant
    in_valid = '0;
    in_valid6 = '1;
    for (int s = 6; s < 8; s++) begin
      sel6 = SW'(s);
      cycle();
      chk("sel_oor_valid6", 32'(out_valid6), 32'd0);
    end
    sel6 = 3'd5;
    in_data6[5*W +: W] = 24'h123456;
    cycle();
    chk("sel5_data6", 32'(out_data6), 32'h123456);
    in_valid6 = '0;

    // Round-robin with all channels valid: 0..7 then wrap
    reset = 1'b1; cycle(); reset = 1'b0;
    mode = 1'b1; in_valid = '1;
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < C; c++) in_data[c*W +: W] = W'($urandom);
      cycle();
      chk("rr_seq", 32'(out_chan), 32'(i % C));
    end

    // Round-robin with channels 0 and 7: 0, then 7, then 0
    reset = 1'b1; cycle(); reset = 1'b0;
    in_valid = 8'b1000_0001;
    exp_seq = '{0, 7, 0};
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rr_wrap", 32'(out_chan), 32'(exp_seq[i]));
    end

    // Backpressure holds the register; release refills in the same cycle
    mode = 1'b0; sel = 3'd1; in_valid = 8'h02; out_ready = 1'b1;
    in_data[1*W +: W] = 24'h00D1D1;
    cycle();
    held = out_data;
    out_ready = 1'b0;
    in_data[1*W +: W] = 24'h00D2D2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_refill_valid", 32'(out_valid), 32'd1);
    chk("bp_refill_data", 32'(out_data), 32'h00D2D2);

    // Drain with no grant: valid drops, data holds
    in_valid = '0;
    cycle();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold", 32'(out_data), 32'h00D2D2);

    // Random traffic with occasional mode flips and mid-stream resets
    for (int t = 0; t < 400; t++) begin
      reset     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      sel       = SW'($urandom);
      in_valid  = C'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < C; c++) in_data[c*W +: W] = W'($urandom);
      sel6      = SW'($urandom);
      in_valid6 = C6'($urandom);
      for (int c = 0; c < C6; c++) in_data6[c*W +: W] = W'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
